link_txn_seq: RTL and testbench

Host-side transaction sequencer for the USB link layer: turns a single OUT/IN command into the full token → data → handshake packet sequence. It drives the PID and start strobe into the transmit path (crc5_t/control_t) and consumes the end-of-packet, PID and CRC results from the receive path (crc5_r/crc16_r). It runs alongside link_control, which owns d_oe and turnaround, and is the initiator that link_control's enables react to. It maintains the DATA0/DATA1 toggle, a response timer and bounded retries.

---
 rtl/usb_pkg.sv | 40 ++++
 rtl/link_txn_seq_if.sv | 43 ++++
 rtl/link_txn_seq.sv | 207 ++++++++++++++++++++
 tb/tb_link_txn_seq.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// USB link-layer shared constants: PID codes, transaction status codes and the
// sequencer state encoding.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_NAK = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;
    localparam logic [1:0] ST_CRC = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TOK,
        S_TOK_WAIT,
        S_DTX,
        S_DTX_WAIT,
        S_HS_WAIT,
        S_RXD_WAIT,
        S_RXD_BODY,
        S_ACK,
        S_ACK_WAIT,
        S_FIN
    } seq_state_e;

    // DATA0 and DATA1 share the low three bits; bit 3 carries the toggle.
    function automatic logic is_data_pid(input logic [3:0] pid);
        return pid[2:0] == PID_DATA0[2:0];
    endfunction

    function automatic logic [3:0] data_pid(input logic tog);
        return tog ? PID_DATA1 : PID_DATA0;
    endfunction

endpackage

// File: rtl/link_txn_seq_if.sv
// Command, transmit-path and receive-path signals of the host transaction
// sequencer. master = sequencer side, slave = the surrounding link layer.
interface link_txn_seq_if;
    import usb_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic       toggle_clr;

    logic [3:0] tx_con_pid;
    logic       tx_con_pid_en;
    logic       tx_lp_eop_en;

    logic       rx_pid_en;
    logic       rx_sop_en;
    logic [3:0] rx_pid;
    logic       rx_lt_eop_en;
    logic       rx_crc_err;

    logic       done;
    logic [1:0] status;
    logic       rx_dup;

    modport master (
        input  cmd_valid, cmd_dir, toggle_clr,
        input  tx_lp_eop_en,
        input  rx_pid_en, rx_sop_en, rx_pid, rx_lt_eop_en, rx_crc_err,
        output cmd_ready,
        output tx_con_pid, tx_con_pid_en,
        output done, status, rx_dup
    );

    modport slave (
        output cmd_valid, cmd_dir, toggle_clr,
        output tx_lp_eop_en,
        output rx_pid_en, rx_sop_en, rx_pid, rx_lt_eop_en, rx_crc_err,
        input  cmd_ready,
        input  tx_con_pid, tx_con_pid_en,
        input  done, status, rx_dup
    );

endinterface

// File: rtl/link_txn_seq.sv
// Host transaction sequencer: expands one OUT/IN command into token, data and
// handshake packets, tracking the data toggle, a response timer and retries.
module link_txn_seq
    import usb_pkg::*;
#(
    parameter int MAX_RETRY = 3,
    parameter int TW        = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ms,
    input  logic [TW-1:0]  time_threshold,
    link_txn_seq_if.master bus,
    output logic           toggle
);

    seq_state_e    state_q, state_d;
    logic          dir_q, dir_d;
    logic [3:0]    retry_q, retry_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] timer_inc;
    logic          toggle_q, toggle_d;
    logic          dup_q, dup_d;
    logic [3:0]    pid_q, pid_d;
    logic          pid_en_q, pid_en_d;
    logic          done_q, done_d;
    logic [1:0]    status_q, status_d;
    logic          rx_dup_q, rx_dup_d;

    logic          fail;
    logic          finish_ok;
    logic [1:0]    cause;
    logic          timeout;

    assign timeout   = (timer_q == time_threshold);
    assign timer_inc = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        retry_d   = retry_q;
        timer_d   = timer_q;
        toggle_d  = toggle_q;
        dup_d     = dup_q;
        pid_d     = pid_q;
        pid_en_d  = 1'b0;
        done_d    = 1'b0;
        status_d  = status_q;
        rx_dup_d  = rx_dup_q;
        fail      = 1'b0;
        finish_ok = 1'b0;
        cause     = ST_OK;

        case (state_q)
            S_IDLE: begin
                if (bus.toggle_clr) toggle_d = 1'b0;
                if (bus.cmd_valid && ms) begin
                    dir_d   = bus.cmd_dir;
                    retry_d = '0;
                    state_d = S_TOK;
                end
            end
            S_TOK: begin
                pid_d    = dir_q ? PID_IN : PID_OUT;
                pid_en_d = 1'b1;
                state_d  = S_TOK_WAIT;
            end
            S_TOK_WAIT: begin
                if (bus.tx_lp_eop_en) begin
                    state_d = dir_q ? S_RXD_WAIT : S_DTX;
                    timer_d = '0;
                end
            end
            S_DTX: begin
                pid_d    = data_pid(toggle_q);
                pid_en_d = 1'b1;
                state_d  = S_DTX_WAIT;
            end
            S_DTX_WAIT: begin
                if (bus.tx_lp_eop_en) begin
                    state_d = S_HS_WAIT;
                    timer_d = '0;
                end
            end
            S_HS_WAIT: begin
                timer_d = timer_inc;
                // A handshake landing on the timeout cycle still counts.
                if (bus.rx_pid_en && bus.rx_pid == PID_ACK) begin
                    toggle_d  = ~toggle_q;
                    finish_ok = 1'b1;
                end else if (bus.rx_pid_en && bus.rx_pid == PID_NAK) begin
                    fail  = 1'b1;
                    cause = ST_NAK;
                end else if (timeout) begin
                    fail  = 1'b1;
                    cause = ST_TMO;
                end
            end
            S_RXD_WAIT: begin
                timer_d = timer_inc;
                if (bus.rx_sop_en && is_data_pid(bus.rx_pid)) begin
                    dup_d   = (bus.rx_pid[3] != toggle_q);
                    state_d = S_RXD_BODY;
                end else if (bus.rx_pid_en && bus.rx_pid == PID_NAK) begin
                    fail  = 1'b1;
                    cause = ST_NAK;
                end else if (timeout) begin
                    fail  = 1'b1;
                    cause = ST_TMO;
                end
            end
            S_RXD_BODY: begin
                if (bus.rx_lt_eop_en) begin
                    if (bus.rx_crc_err) begin
                        fail  = 1'b1;
                        cause = ST_CRC;
                    end else begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                pid_d    = PID_ACK;
                pid_en_d = 1'b1;
                state_d  = S_ACK_WAIT;
            end
            S_ACK_WAIT: begin
                if (bus.tx_lp_eop_en) begin
                    // A duplicate is still ACKed but must not advance the toggle.
                    if (!dup_q) toggle_d = ~toggle_q;
                    finish_ok = 1'b1;
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (finish_ok) begin
            status_d = ST_OK;
            rx_dup_d = dir_q & dup_q;
            done_d   = 1'b1;
            state_d  = S_FIN;
        end

        if (fail) begin
            if (retry_q < 4'(MAX_RETRY)) begin
                retry_d = retry_q + 4'd1;
                state_d = S_TOK;
            end else begin
                status_d = cause;
                rx_dup_d = 1'b0;
                done_d   = 1'b1;
                state_d  = S_FIN;
            end
        end

        // Losing mastership abandons the transaction silently; toggle survives.
        if (!ms) begin
            state_d  = S_IDLE;
            pid_d    = 4'b0000;
            pid_en_d = 1'b0;
            done_d   = 1'b0;
            status_d = ST_OK;
            rx_dup_d = 1'b0;
            timer_d  = '0;
            retry_d  = '0;
            if (state_q != S_IDLE) toggle_d = toggle_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dir_q    <= 1'b0;
            retry_q  <= '0;
            timer_q  <= '0;
            toggle_q <= 1'b0;
            dup_q    <= 1'b0;
            pid_q    <= 4'b0000;
            pid_en_q <= 1'b0;
            done_q   <= 1'b0;
            status_q <= ST_OK;
            rx_dup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            retry_q  <= retry_d;
            timer_q  <= timer_d;
            toggle_q <= toggle_d;
            dup_q    <= dup_d;
            pid_q    <= pid_d;
            pid_en_q <= pid_en_d;
            done_q   <= done_d;
            status_q <= status_d;
            rx_dup_q <= rx_dup_d;
        end
    end

    assign bus.cmd_ready     = (state_q == S_IDLE) && ms;
    assign bus.tx_con_pid    = pid_q;
    assign bus.tx_con_pid_en = pid_en_q;
    assign bus.done          = done_q;
    assign bus.status        = status_q;
    assign bus.rx_dup        = rx_dup_q;
    assign toggle            = toggle_q;

endmodule

// File: tb/tb_link_txn_seq.sv
// Bench for link_txn_seq: a scripted device answers each attempt and a
// transaction-level model predicts packets, latencies, status and toggle.
module tb_link_txn_seq;
    import usb_pkg::*;

    localparam int MAX_RETRY = 3;
    localparam int TW        = 16;

    typedef enum int {R_ACK, R_NAK, R_SIL, R_D0, R_D1, R_D0E, R_D1E} resp_e;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ms;
    logic [TW-1:0] thr;
    logic          toggle;

    link_txn_seq_if bus();

    link_txn_seq #(.MAX_RETRY(MAX_RETRY), .TW(TW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ms            (ms),
        .time_threshold(thr),
        .bus           (bus.master),
        .toggle        (toggle)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    done_seen = 0;
    int    m_done = 0;
    bit    m_tog = 1'b0;
    resp_e plan [4];

    always @(negedge clk) if (bus.done === 1'b1) done_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change at the falling edge; single-cycle pulses drop on the next one.
    task automatic tick();
        @(negedge clk);
        bus.cmd_valid    = 1'b0;
        bus.tx_lp_eop_en = 1'b0;
        bus.rx_pid_en    = 1'b0;
        bus.rx_sop_en    = 1'b0;
        bus.rx_lt_eop_en = 1'b0;
    endtask

    task automatic wait_strobe(input string tag, input logic [3:0] pid, input int lat);
        int k = 0;
        bit seen = 1'b0;
        while (k < 200 && !seen) begin
            tick();
            k++;
            if (bus.tx_con_pid_en === 1'b1) seen = 1'b1;
        end
        chk({tag, "_seen"}, 32'(seen), 1);
        if (seen) begin
            chk({tag, "_pid"}, 32'(bus.tx_con_pid), 32'(pid));
            chk({tag, "_lat"}, k, lat);
        end
    endtask

    task automatic wait_done(input string tag, input int lat, input logic [1:0] st, input bit dup);
        int k = 0;
        bit seen = 1'b0;
        while (k < 300 && !seen) begin
            tick();
            k++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk({tag, "_done"}, 32'(seen), 1);
        if (seen) begin
            chk({tag, "_lat"}, k, lat);
            chk({tag, "_status"}, 32'(bus.status), 32'(st));
            chk({tag, "_rxdup"}, 32'(bus.rx_dup), 32'(dup));
            chk({tag, "_toggle"}, 32'(toggle), 32'(m_tog));
            tick();
            chk({tag, "_done_1cyc"}, 32'(bus.done), 0);
            chk({tag, "_ready"}, 32'(bus.cmd_ready), 1);
        end
        m_done++;
    endtask

    // Send the token and data packets' end-of-packet a few cycles after the strobe.
    task automatic send_eop();
        repeat (1 + $urandom_range(0, 2)) tick();
        bus.tx_lp_eop_en = 1'b1;
    endtask

    task automatic run_cmd(input string tag, input bit dir, input int thr_v);
        int    tok_lat = 2;
        int    d;
        int    fin_lat;
        bit    ok;
        bit    dup;
        bit    pbit;
        logic [1:0] st;
        resp_e r;
        thr = TW'(thr_v);
        chk({tag, "_ready_in"}, 32'(bus.cmd_ready), 1);
        bus.cmd_dir   = dir;
        bus.cmd_valid = 1'b1;
        for (int a = 0; a <= MAX_RETRY; a++) begin
            r = plan[a];
            wait_strobe({tag, "_tok"}, dir ? PID_IN : PID_OUT, tok_lat);
            send_eop();
            if (!dir) begin
                wait_strobe({tag, "_dtx"}, m_tog ? PID_DATA1 : PID_DATA0, 2);
                send_eop();
            end
            tick();
            d = $urandom_range(0, thr_v);
            fin_lat = 1;
            tok_lat = 2;
            if (r == R_SIL) begin
                fin_lat = thr_v + 1;
                tok_lat = thr_v + 2;
            end else begin
                if (!dir && d > 0 && $urandom_range(0, 1) == 1) begin
                    bus.rx_pid_en    = 1'b1;
                    bus.rx_pid       = PID_IN;
                    bus.tx_lp_eop_en = 1'b1;
                end
                repeat (d) tick();
                if (r == R_ACK || r == R_NAK) begin
                    bus.rx_pid_en = 1'b1;
                    bus.rx_pid    = (r == R_ACK) ? PID_ACK : PID_NAK;
                end else begin
                    pbit = (r == R_D1 || r == R_D1E);
                    bus.rx_sop_en = 1'b1;
                    bus.rx_pid    = pbit ? PID_DATA1 : PID_DATA0;
                    repeat (1 + $urandom_range(0, 3)) tick();
                    bus.rx_lt_eop_en = 1'b1;
                    bus.rx_crc_err   = (r == R_D0E || r == R_D1E);
                    if (r == R_D0 || r == R_D1) begin
                        wait_strobe({tag, "_ack"}, PID_ACK, 2);
                        send_eop();
                    end
                end
            end
            ok  = (r == R_ACK || r == R_D0 || r == R_D1);
            dup = 1'b0;
            if (ok) begin
                if (dir) begin
                    dup = (pbit != m_tog);
                    if (!dup) m_tog = ~m_tog;
                end else begin
                    m_tog = ~m_tog;
                end
                wait_done(tag, 1, ST_OK, dup);
                bus.rx_crc_err = 1'b0;
                return;
            end
            st = (r == R_NAK) ? ST_NAK : (r == R_SIL) ? ST_TMO : ST_CRC;
            if (a == MAX_RETRY) begin
                wait_done(tag, fin_lat, st, 1'b0);
                bus.rx_crc_err = 1'b0;
                return;
            end
        end
    endtask

    task automatic fill(input resp_e r0, input resp_e r1, input resp_e r2, input resp_e r3);
        plan[0] = r0; plan[1] = r1; plan[2] = r2; plan[3] = r3;
    endtask

    task automatic check_idle_outputs(input string tag, input bit ready);
        chk({tag, "_ready"},  32'(bus.cmd_ready), 32'(ready));
        chk({tag, "_pid"},    32'(bus.tx_con_pid), 0);
        chk({tag, "_pid_en"}, 32'(bus.tx_con_pid_en), 0);
        chk({tag, "_done"},   32'(bus.done), 0);
        chk({tag, "_status"}, 32'(bus.status), 0);
        chk({tag, "_rxdup"},  32'(bus.rx_dup), 0);
        chk({tag, "_toggle"}, 32'(toggle), 32'(m_tog));
    endtask

    initial begin
        resp_e out_set [3];
        resp_e in_set  [6];
        bit    dir;
        out_set = '{R_ACK, R_NAK, R_SIL};
        in_set  = '{R_D0, R_D1, R_D0E, R_D1E, R_NAK, R_SIL};

        rst_n = 1'b0;
        ms    = 1'b1;
        thr   = TW'(10);
        bus.cmd_valid    = 1'b0;
        bus.cmd_dir      = 1'b0;
        bus.toggle_clr   = 1'b0;
        bus.tx_lp_eop_en = 1'b0;
        bus.rx_pid_en    = 1'b0;
        bus.rx_sop_en    = 1'b0;
        bus.rx_pid       = 4'b0000;
        bus.rx_lt_eop_en = 1'b0;
        bus.rx_crc_err   = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset", 1'b1);
        rst_n = 1'b1;
        tick();
        check_idle_outputs("post_reset", 1'b1);

        // Directed cases
        fill(R_ACK, R_ACK, R_ACK, R_ACK);
        run_cmd("out_ack", 1'b0, 8);
        fill(R_D1, R_D1, R_D1, R_D1);
        run_cmd("in_d1", 1'b1, 8);
        run_cmd("in_d1_dup", 1'b1, 8);
        fill(R_NAK, R_NAK, R_NAK, R_NAK);
        run_cmd("out_nak_x4", 1'b0, 8);
        fill(R_SIL, R_SIL, R_SIL, R_SIL);
        run_cmd("in_tmo_x4", 1'b1, 10);
        fill(R_D0E, R_D0, R_D0, R_D0);
        run_cmd("in_crc_retry", 1'b1, 6);
        fill(R_ACK, R_ACK, R_ACK, R_ACK);
        run_cmd("out_thr0", 1'b0, 0);
        fill(R_SIL, R_NAK, R_SIL, R_D1E);
        run_cmd("in_crc_x_mix", 1'b1, 0);

        // Randomized commands
        for (int i = 0; i < 40; i++) begin
            dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                bus.toggle_clr = 1'b1;
                tick();
                bus.toggle_clr = 1'b0;
                m_tog = 1'b0;
                chk("toggle_clr", 32'(toggle), 0);
            end
            for (int a = 0; a < 4; a++)
                plan[a] = dir ? in_set[$urandom_range(0, 5)] : out_set[$urandom_range(0, 2)];
            run_cmd("rand", dir, $urandom_range(0, 30));
        end

        // Reset while waiting for the data packet EOP
        if (!m_tog) begin
            fill(R_ACK, R_ACK, R_ACK, R_ACK);
            run_cmd("pre_rst", 1'b0, 5);
        end
        bus.cmd_dir   = 1'b0;
        bus.cmd_valid = 1'b1;
        wait_strobe("rst_tok", PID_OUT, 2);
        send_eop();
        wait_strobe("rst_dtx", PID_DATA1, 2);
        tick();
        rst_n = 1'b0;
        #1;
        m_tog = 1'b0;
        check_idle_outputs("rst_dtxw", 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        check_idle_outputs("rst_rel", 1'b1);

        // ms dropped while waiting for the handshake
        fill(R_NAK, R_NAK, R_NAK, R_NAK);
        run_cmd("pre_ms", 1'b0, 5);
        bus.cmd_dir   = 1'b0;
        bus.cmd_valid = 1'b1;
        wait_strobe("ms_tok", PID_OUT, 2);
        send_eop();
        wait_strobe("ms_dtx", m_tog ? PID_DATA1 : PID_DATA0, 2);
        send_eop();
        repeat (2) tick();
        ms = 1'b0;
        tick();
        check_idle_outputs("ms_drop", 1'b0);
        bus.rx_pid_en = 1'b1;
        bus.rx_pid    = PID_ACK;
        tick();
        ms = 1'b1;
        tick();
        check_idle_outputs("ms_back", 1'b1);

        repeat (5) tick();
        chk("done_count", done_seen, m_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
